// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing one config register port among PORTS requesters, one transaction in flight.
// Write: strobe 1 cycle after grant, ack 1 later; read: ack 1 cycle after m_rvalid or RD_TIMEOUT error; requesters wait on s_ack.
module cfg_bus_arbiter #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              s_req,
    input  logic [PORTS-1:0]              s_we,
    input  logic [PORTS*ADDR_WIDTH-1:0]   s_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_wdata,
    output logic [PORTS-1:0]              s_ack,
    output logic                          s_err,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic                          m_wr,
    output logic                          m_rd,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    logic [GW-1:0]           last_grant;
    logic [GW-1:0]           grant;
    logic                    we_q;
    logic [CW-1:0]           cnt;

    logic                    found;
    logic [GW-1:0]           pick;
    logic [GW-1:0]           cand;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        cand  = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = GW'((int'(last_grant) + i) % PORTS);
            if (!found && s_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (pick == GW'(i)) begin
                sel_we    = s_we[i];
                sel_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(PORTS - 1);
            grant      <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            s_ack      <= '0;
            s_err      <= 1'b0;
            s_rdata    <= '0;
            m_wr       <= 1'b0;
            m_rd       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            m_wr  <= 1'b0;
            m_rd  <= 1'b0;
            s_ack <= '0;
            case (state)
                IDLE: begin
                    // Strobes are registered here so they are high during ISSUE.
                    if (found) begin
                        grant      <= pick;
                        last_grant <= pick;
                        we_q       <= sel_we;
                        m_addr     <= sel_addr;
                        if (sel_we) begin
                            m_wr    <= 1'b1;
                            m_wdata <= sel_wdata;
                        end else begin
                            m_rd    <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (we_q) begin
                        s_ack[grant] <= 1'b1;
                        s_err        <= 1'b0;
                        state        <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        s_ack[grant] <= 1'b1;
                        s_rdata      <= m_rdata;
                        s_err        <= 1'b0;
                        state        <= RESP;
                    end else if (cnt == CW'(RD_TIMEOUT - 2)) begin
                        s_ack[grant] <= 1'b1;
                        s_rdata      <= '0;
                        s_err        <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed bench for cfg_bus_arbiter (PORTS=2, RD_TIMEOUT=16); values sampled 1 time unit after each rising edge.
module tb_cfg_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   s_req;
    logic [1:0]   s_we;
    logic [63:0]  s_addr;
    logic [63:0]  s_wdata;
    logic [1:0]   s_ack;
    logic         s_err;
    logic [31:0]  s_rdata;
    logic         m_wr;
    logic         m_rd;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_rvalid;

    int errs   = 0;
    int checks = 0;

    cfg_bus_arbiter #(
        .PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
        .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   64'(s_ack),   64'h0);
        check({tag, "_err"},   64'(s_err),   64'h0);
        check({tag, "_rdata"}, 64'(s_rdata), 64'h0);
        check({tag, "_wr"},    64'(m_wr),    64'h0);
        check({tag, "_rd"},    64'(m_rd),    64'h0);
        check({tag, "_addr"},  64'(m_addr),  64'h0);
        check({tag, "_wdata"}, 64'(m_wdata), 64'h0);
    endtask

    logic [1:0] ack_log[$];
    int         n;
    logic       done;

    initial begin
        rst = 1'b1; s_req = '0; s_we = '0; s_addr = '0; s_wdata = '0;
        m_rdata = '0; m_rvalid = 1'b0;
        tick(); tick();
        check_idle_outputs("rst");

        // 1: port 0 write, dropped right after grant; ack must still come
        rst = 1'b0;
        s_req = 2'b01; s_we = 2'b01;
        s_addr = {32'h0, 32'h10}; s_wdata = {32'h0, 32'hA5A5_0001};
        tick();
        check("t1_wr",    64'(m_wr),    64'h1);
        check("t1_rd",    64'(m_rd),    64'h0);
        check("t1_addr",  64'(m_addr),  64'h10);
        check("t1_wdata", 64'(m_wdata), 64'hA5A5_0001);
        check("t1_noack", 64'(s_ack),   64'h0);
        s_req = '0;
        tick();
        check("t1_wr_off", 64'(m_wr),  64'h0);
        check("t1_ack",    64'(s_ack), 64'h1);
        check("t1_err",    64'(s_err), 64'h0);
        tick();
        check("t1_ack_off", 64'(s_ack),  64'h0);
        check("t1_addr_hold", 64'(m_addr), 64'h10);

        // 2: port 1 read, rvalid two cycles after m_rd
        s_req = 2'b10; s_we = 2'b00; s_addr = {32'h20, 32'h0};
        tick();
        check("t2_rd",   64'(m_rd),   64'h1);
        check("t2_wr",   64'(m_wr),   64'h0);
        check("t2_addr", 64'(m_addr), 64'h20);
        s_req = '0;
        tick();
        check("t2_rd_off", 64'(m_rd), 64'h0);
        tick();
        check("t2_noack", 64'(s_ack), 64'h0);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("t2_ack",   64'(s_ack),   64'h2);
        check("t2_rdata", 64'(s_rdata), 64'h1234_5678);
        check("t2_err",   64'(s_err),   64'h0);
        tick();

        // 4: port 0 read timeout (port 0 is next in rotation)
        s_req = 2'b01; s_we = 2'b00; s_addr = {32'h0, 32'h40};
        tick();
        check("t4_rd", 64'(m_rd), 64'h1);
        s_req = '0;
        n = 0; done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            tick();
            if (s_ack != 2'b00) begin
                n = k;
                done = 1'b1;
            end
        end
        check("t4_latency", 64'(n),       64'd16);
        check("t4_ack",     64'(s_ack),   64'h1);
        check("t4_err",     64'(s_err),   64'h1);
        check("t4_rdata",   64'(s_rdata), 64'h0);
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("t4_late_ack",   64'(s_ack),   64'h0);
        check("t4_late_rdata", 64'(s_rdata), 64'h0);

        // 5: rvalid during ISSUE ignored, first WAIT-cycle value captured
        s_req = 2'b10; s_we = 2'b00; s_addr = {32'h50, 32'h0};
        tick();
        check("t5_rd", 64'(m_rd), 64'h1);
        s_req = '0;
        m_rvalid = 1'b1; m_rdata = 32'h0000_BEEF;
        tick();
        check("t5_issue_ign", 64'(s_ack), 64'h0);
        m_rdata = 32'h0000_CAFE;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("t5_ack",   64'(s_ack),   64'h2);
        check("t5_rdata", 64'(s_rdata), 64'h0000_CAFE);
        check("t5_err",   64'(s_err),   64'h0);
        tick();

        // 3: both ports write continuously after reset
        rst = 1'b1;
        s_req = 2'b11; s_we = 2'b11;
        s_addr = {32'h200, 32'h100}; s_wdata = {32'h2222, 32'h1111};
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("t3_wr_rd_excl", 64'(m_wr & m_rd), 64'h0);
            if (s_ack != 2'b00) begin
                ack_log.push_back(s_ack);
                check("t3_addr_at_ack", 64'(m_addr), (s_ack == 2'b01) ? 64'h100 : 64'h200);
            end
            if (k == 17) s_req = '0;
        end
        check("t3_ack_count", 64'(ack_log.size()), 64'd6);
        for (int k = 0; k < ack_log.size(); k++)
            check("t3_grant_order", 64'(ack_log[k]), (k % 2 == 0) ? 64'h1 : 64'h2);

        // 6: reset during WAIT aborts the read; port 0 wins first afterwards
        s_req = 2'b10; s_we = 2'b00; s_addr = {32'h60, 32'h70};
        tick();
        check("t6_rd", 64'(m_rd), 64'h1);
        tick(); tick();
        rst = 1'b1; s_req = '0;
        tick();
        check_idle_outputs("t6_rst");
        rst = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("t6_late_ack",   64'(s_ack),   64'h0);
        check("t6_late_rdata", 64'(s_rdata), 64'h0);
        tick();
        check("t6_no_ack", 64'(s_ack), 64'h0);
        s_req = 2'b11; s_we = 2'b11;
        s_addr = {32'h80, 32'h90}; s_wdata = {32'h8888, 32'h9999};
        tick();
        check("t6_wr",    64'(m_wr),    64'h1);
        check("t6_addr",  64'(m_addr),  64'h90);
        check("t6_wdata", 64'(m_wdata), 64'h9999);
        s_req = '0;
        tick();
        check("t6_ack", 64'(s_ack), 64'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cfg_bus_arbiter.md
Name: cfg_bus_arbiter

Overview:
Shares one simple config register port (wr/rd/addr/wdata/rdata/rvalid, the same port style as the config-bus bridges drive) among PORTS independent requesters.
- Arbitration is round-robin; one transaction is in flight at a time.
- Each transaction is sequenced through a small FSM, and a read-response timeout guards against a target that never returns rvalid.
- Sits between several register masters (AXI config bridges, local CPU, init sequencer) and a single register file or peripheral decoder.

Parameters:
PORTS, 2, number of requesters (>=2)
ADDR_WIDTH, 32, register address width
DATA_WIDTH, 32, register data width
RD_TIMEOUT, 16, cycles to wait for m_rvalid after m_rd before erroring (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
s_req  input  PORTS  per-port request level; held until s_ack
s_we  input  PORTS  per-port 1=write, 0=read; stable while s_req high
s_addr  input  PORTS*ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
s_wdata  input  PORTS*DATA_WIDTH  per-port write data, packed as s_addr
s_ack  output  PORTS  one-cycle completion pulse to the granted port
s_err  output  1  valid with s_ack; 1 = read timed out
s_rdata  output  DATA_WIDTH  read data, valid with s_ack on reads
m_wr  output  1  one-cycle write strobe
m_rd  output  1  one-cycle read strobe
m_addr  output  ADDR_WIDTH  shared address for m_wr/m_rd
m_wdata  output  DATA_WIDTH  write data, valid with m_wr
m_rdata  input  DATA_WIDTH  read data from target
m_rvalid  input  1  read data valid

Behaviour:
- All outputs are registered. Reset values:
  - s_ack=0, s_err=0, s_rdata=0.
  - m_wr=0, m_rd=0, m_addr=0, m_wdata=0.
  - Internal state: FSM=IDLE, last_grant=PORTS-1 (port 0 wins first), timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any s_req is high, grant the first requesting port scanning from (last_grant+1) mod PORTS upward with wrap.
  - Latch grant index, s_we, s_addr and s_wdata of that port; update last_grant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - m_addr = latched address for the whole transaction; m_addr holds its value after completion.
  - Write: m_wr=1, m_wdata = latched data, next state RESP.
  - Read: m_rd=1, clear the timeout counter, next state WAIT.
- WAIT:
  - m_rvalid is honoured only in this state; m_rvalid during ISSUE, IDLE or RESP is ignored.
  - On m_rvalid: capture m_rdata into s_rdata, s_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT-1 without m_rvalid, set s_rdata=0, s_err=1, go to RESP.
  - If m_rvalid and timeout coincide, m_rvalid wins (s_err=0).
- RESP (one cycle):
  - s_ack[grant]=1; every other s_ack bit is 0.
  - s_err/s_rdata are valid this cycle. For writes s_err=0 and s_rdata holds its previous value.
  - Next state IDLE.
- Requester rule: s_req must be deasserted on the clock edge at which s_ack is high. A req still high in the following IDLE cycle is treated as a new request.
- Latency from s_req sampled in IDLE:
  - Write: m_wr the next cycle, s_ack the cycle after.
  - Read: m_rd the next cycle, then N cycles to m_rvalid, then s_ack one cycle later.
  - Minimum write throughput: 1 transaction per 3 cycles.
- m_wr and m_rd are never high in the same cycle; at most one strobe per transaction.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,PORTS-1,0.
- A port dropping s_req after grant does not abort the transaction; the ack is still issued.
- Reset mid-transaction:
  - Return to IDLE with reset values next edge; no ack is issued for the aborted transaction.
  - A late m_rvalid arriving in IDLE is ignored.

Test Plan:
1. Port 0 write addr=0x10 data=0xA5A5_0001 -> m_wr one cycle later with m_addr=0x10, m_wdata=0xA5A5_0001; s_ack[0] the next cycle; s_err=0; total 3 cycles.
2. Port 1 read addr=0x20; target returns m_rvalid 2 cycles after m_rd with 0x1234_5678 -> s_ack[1] one cycle after m_rvalid; s_rdata=0x1234_5678; s_err=0.
3. Ports 0 and 1 both request continuously for 6 transactions after reset -> grant order 0,1,0,1,0,1; never two s_ack bits high; never m_wr&m_rd.
4. Read with no m_rvalid, RD_TIMEOUT=16 -> s_ack with s_err=1, s_rdata=0 exactly 16 cycles after m_rd; subsequent m_rvalid pulse ignored; next request serviced normally.
5. m_rvalid asserted during ISSUE and again in the first WAIT cycle with 0xCAFE -> ISSUE pulse ignored; the WAIT-cycle value is captured; s_rdata=0xCAFE.
6. rst asserted in WAIT -> next cycle all outputs 0, FSM IDLE, no s_ack; m_rvalid then ignored; port 0 wins the first grant after reset.
